// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_operand_stage
// Purpose  : ID/EX pipeline register with M/W operand forwarding ahead of the
//            ALU. Forwarding is built only when EX_FORWARD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ex_operand_stage #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stallE,
   input  logic         flushE,
   input  logic [N-1:0] rd1D,
   input  logic [N-1:0] rd2D,
   input  logic [N-1:0] signimmD,
   input  logic [4:0]   rsD,
   input  logic [4:0]   rtD,
   input  logic [4:0]   rdD,
   input  logic         regwriteD,
   input  logic         memtoregD,
   input  logic         memwriteD,
   input  logic         alusrcD,
   input  logic         regdstD,
   input  logic [2:0]   alucontrolD,
   input  logic         regwriteM,
   input  logic [4:0]   writeregM,
   input  logic [N-1:0] aluoutM,
   input  logic         regwriteW,
   input  logic [4:0]   writeregW,
   input  logic [N-1:0] resultW,
   output logic [N-1:0] srcaE,
   output logic [N-1:0] srcbE,
   output logic [2:0]   alucontrolE,
   output logic [N-1:0] writedataE,
   output logic [4:0]   writeregE,
   output logic [4:0]   rsE,
   output logic [4:0]   rtE,
   output logic         regwriteE,
   output logic         memtoregE,
   output logic         memwriteE,
   output logic         validE,
   output logic [1:0]   forwardaE,
   output logic [1:0]   forwardbE
);

   localparam logic [4:0] c_reg_zero = 5'd0;
   localparam logic [1:0] c_fwd_none = 2'b00;
   localparam logic [1:0] c_fwd_wb   = 2'b01;
   localparam logic [1:0] c_fwd_mem  = 2'b10;

   logic [N-1:0] r_rd1;
   logic [N-1:0] r_rd2;
   logic [N-1:0] r_signimm;
   logic [4:0]   r_rs;
   logic [4:0]   r_rt;
   logic [4:0]   r_rd;
   logic         r_regwrite;
   logic         r_memtoreg;
   logic         r_memwrite;
   logic         r_alusrc;
   logic         r_regdst;
   logic [2:0]   r_alucontrol;
   logic         r_valid;

   logic [1:0]   w_forwarda;
   logic [1:0]   w_forwardb;
   logic [N-1:0] w_srca;
   logic [N-1:0] w_writedata;

   // A flush loads an all-zero bubble, so it never looks like a real write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd1        <= '0;
         r_rd2        <= '0;
         r_signimm    <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_regwrite   <= 1'b0;
         r_memtoreg   <= 1'b0;
         r_memwrite   <= 1'b0;
         r_alusrc     <= 1'b0;
         r_regdst     <= 1'b0;
         r_alucontrol <= '0;
         r_valid      <= 1'b0;
      end else if (flushE) begin
         r_rd1        <= '0;
         r_rd2        <= '0;
         r_signimm    <= '0;
         r_rs         <= '0;
         r_rt         <= '0;
         r_rd         <= '0;
         r_regwrite   <= 1'b0;
         r_memtoreg   <= 1'b0;
         r_memwrite   <= 1'b0;
         r_alusrc     <= 1'b0;
         r_regdst     <= 1'b0;
         r_alucontrol <= '0;
         r_valid      <= 1'b0;
      end else if (!stallE) begin
         r_rd1        <= rd1D;
         r_rd2        <= rd2D;
         r_signimm    <= signimmD;
         r_rs         <= rsD;
         r_rt         <= rtD;
         r_rd         <= rdD;
         r_regwrite   <= regwriteD;
         r_memtoreg   <= memtoregD;
         r_memwrite   <= memwriteD;
         r_alusrc     <= alusrcD;
         r_regdst     <= regdstD;
         r_alucontrol <= alucontrolD;
         r_valid      <= 1'b1;
      end
   end

`ifdef EX_FORWARD_EN
   // Memory stage is checked first: it holds the younger result.
   always_comb begin
      w_forwarda = c_fwd_none;
      if ((r_rs != c_reg_zero) && regwriteM && (r_rs == writeregM))
         w_forwarda = c_fwd_mem;
      else if ((r_rs != c_reg_zero) && regwriteW && (r_rs == writeregW))
         w_forwarda = c_fwd_wb;
   end

   always_comb begin
      w_forwardb = c_fwd_none;
      if ((r_rt != c_reg_zero) && regwriteM && (r_rt == writeregM))
         w_forwardb = c_fwd_mem;
      else if ((r_rt != c_reg_zero) && regwriteW && (r_rt == writeregW))
         w_forwardb = c_fwd_wb;
   end

   always_comb begin
      w_srca = r_rd1;
      case (w_forwarda)
         c_fwd_mem: w_srca = aluoutM;
         c_fwd_wb:  w_srca = resultW;
         default:   w_srca = r_rd1;
      endcase
   end

   always_comb begin
      w_writedata = r_rd2;
      case (w_forwardb)
         c_fwd_mem: w_writedata = aluoutM;
         c_fwd_wb:  w_writedata = resultW;
         default:   w_writedata = r_rd2;
      endcase
   end
`else
   logic w_unused_fwd;

   assign w_forwarda   = c_fwd_none;
   assign w_forwardb   = c_fwd_none;
   assign w_srca       = r_rd1;
   assign w_writedata  = r_rd2;
   // Forwarding inputs stay on the port list so both builds share one shell.
   assign w_unused_fwd = ^{regwriteM, writeregM, aluoutM, regwriteW, writeregW, resultW};
`endif

   assign forwardaE   = w_forwarda;
   assign forwardbE   = w_forwardb;
   assign srcaE       = w_srca;
   assign writedataE  = w_writedata;
   assign srcbE       = r_alusrc ? r_signimm : w_writedata;
   assign writeregE   = r_regdst ? r_rd : r_rt;
   assign alucontrolE = r_alucontrol;
   assign rsE         = r_rs;
   assign rtE         = r_rt;
   assign regwriteE   = r_regwrite;
   assign memtoregE   = r_memtoreg;
   assign memwriteE   = r_memwrite;
   assign validE      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_operand_stage
// Purpose  : Directed vector table plus stall/flush/reset sequences for
//            ex_operand_stage; expectations follow EX_FORWARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;

`ifdef EX_FORWARD_EN
   localparam bit c_fwd = 1'b1;
`else
   localparam bit c_fwd = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        stallE, flushE;
   logic [31:0] rd1D, rd2D, signimmD;
   logic [4:0]  rsD, rtD, rdD;
   logic        regwriteD, memtoregD, memwriteD, alusrcD, regdstD;
   logic [2:0]  alucontrolD;
   logic        regwriteM, regwriteW;
   logic [4:0]  writeregM, writeregW;
   logic [31:0] aluoutM, resultW;
   logic [31:0] srcaE, srcbE, writedataE;
   logic [2:0]  alucontrolE;
   logic [4:0]  writeregE, rsE, rtE;
   logic        regwriteE, memtoregE, memwriteE, validE;
   logic [1:0]  forwardaE, forwardbE;

   int n_checks = 0;
   int n_fail   = 0;

   ex_operand_stage #(.N(32)) dut (
      .clk(clk), .reset(reset), .stallE(stallE), .flushE(flushE),
      .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD),
      .rsD(rsD), .rtD(rtD), .rdD(rdD),
      .regwriteD(regwriteD), .memtoregD(memtoregD), .memwriteD(memwriteD),
      .alusrcD(alusrcD), .regdstD(regdstD), .alucontrolD(alucontrolD),
      .regwriteM(regwriteM), .writeregM(writeregM), .aluoutM(aluoutM),
      .regwriteW(regwriteW), .writeregW(writeregW), .resultW(resultW),
      .srcaE(srcaE), .srcbE(srcbE), .alucontrolE(alucontrolE),
      .writedataE(writedataE), .writeregE(writeregE),
      .rsE(rsE), .rtE(rtE),
      .regwriteE(regwriteE), .memtoregE(memtoregE), .memwriteE(memwriteE),
      .validE(validE), .forwardaE(forwardaE), .forwardbE(forwardbE)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rs, rt, rd;
      logic [31:0] rd1, rd2, imm;
      logic        alusrc, regdst;
      logic [2:0]  alu;
      logic        rw_m;
      logic [4:0]  wr_m;
      logic [31:0] aluout_m;
      logic        rw_w;
      logic [4:0]  wr_w;
      logic [31:0] res_w;
      logic [4:0]  e_wreg;
      logic [1:0]  e_fa;
      logic [31:0] e_srca;
      logic [1:0]  e_fb;
      logic [31:0] e_wd, e_srcb;
      logic [31:0] n_srca, n_wd, n_srcb;
   } vec_t;

   vec_t vec [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mw();
      regwriteM = 1'b0; writeregM = 5'd0; aluoutM = 32'h0;
      regwriteW = 1'b0; writeregW = 5'd0; resultW = 32'h0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".validE"},      {31'd0, validE},     32'd0);
      chk({tag, ".regwriteE"},   {31'd0, regwriteE},  32'd0);
      chk({tag, ".memwriteE"},   {31'd0, memwriteE},  32'd0);
      chk({tag, ".memtoregE"},   {31'd0, memtoregE},  32'd0);
      chk({tag, ".alucontrolE"}, {29'd0, alucontrolE}, 32'd0);
      chk({tag, ".writeregE"},   {27'd0, writeregE},  32'd0);
      chk({tag, ".rsE"},         {27'd0, rsE},        32'd0);
      chk({tag, ".rtE"},         {27'd0, rtE},        32'd0);
      chk({tag, ".srcaE"},       srcaE,               32'd0);
      chk({tag, ".srcbE"},       srcbE,               32'd0);
      chk({tag, ".writedataE"},  writedataE,          32'd0);
      chk({tag, ".forwardaE"},   {30'd0, forwardaE},  32'd0);
      chk({tag, ".forwardbE"},   {30'd0, forwardbE},  32'd0);
   endtask

   initial begin
      //          rs     rt     rd     rd1           rd2           imm            as    rdst  alu     rwM   wrM    aluoutM       rwW   wrW    resultW       wreg   fa     srca          fb     wd            srcb           n_srca        n_wd          n_srcb
      vec[0] = '{5'd3, 5'd4, 5'd0,  32'h5,        32'h7,        32'h0,         1'b0, 1'b0, 3'b010, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd4,  2'b00, 32'h5,        2'b00, 32'h7,        32'h7,         32'h5,        32'h7,        32'h7};
      vec[1] = '{5'd3, 5'd4, 5'd0,  32'h5,        32'h7,        32'h0,         1'b0, 1'b0, 3'b010, 1'b1, 5'd3,  32'h10,       1'b0, 5'd0,  32'h0,        5'd4,  2'b10, 32'h10,       2'b00, 32'h7,        32'h7,         32'h5,        32'h7,        32'h7};
      vec[2] = '{5'd1, 5'd4, 5'd0,  32'h11,       32'h22,       32'hFFFFFFFC,  1'b1, 1'b0, 3'b110, 1'b1, 5'd4,  32'h20,       1'b1, 5'd4,  32'h30,       5'd4,  2'b00, 32'h11,       2'b10, 32'h20,       32'hFFFFFFFC,  32'h11,       32'h22,       32'hFFFFFFFC};
      vec[3] = '{5'd0, 5'd2, 5'd0,  32'hAB,       32'hCD,       32'h0,         1'b0, 1'b0, 3'b000, 1'b1, 5'd0,  32'h99,       1'b0, 5'd0,  32'h0,        5'd2,  2'b00, 32'hAB,       2'b00, 32'hCD,       32'hCD,        32'hAB,       32'hCD,       32'hCD};
      vec[4] = '{5'd5, 5'd6, 5'd9,  32'h1,        32'h2,        32'h0,         1'b0, 1'b1, 3'b001, 1'b0, 5'd5,  32'h77,       1'b1, 5'd5,  32'h55,       5'd9,  2'b01, 32'h55,       2'b00, 32'h2,        32'h2,         32'h1,        32'h2,        32'h2};
      vec[5] = '{5'd7, 5'd7, 5'd0,  32'h3,        32'h4,        32'h0,         1'b0, 1'b0, 3'b111, 1'b1, 5'd7,  32'h70,       1'b0, 5'd0,  32'h0,        5'd7,  2'b10, 32'h70,       2'b10, 32'h70,       32'h70,        32'h3,        32'h4,        32'h4};
      vec[6] = '{5'd9, 5'd8, 5'd0,  32'hA,        32'hB,        32'h0,         1'b0, 1'b0, 3'b011, 1'b1, 5'd9,  32'h90,       1'b1, 5'd8,  32'h80,       5'd8,  2'b10, 32'h90,       2'b01, 32'h80,       32'h80,        32'hA,        32'hB,        32'hB};
      vec[7] = '{5'd2, 5'd3, 5'd31, 32'h12,       32'h13,       32'h100,       1'b1, 1'b1, 3'b100, 1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h33,       5'd31, 2'b00, 32'h12,       2'b01, 32'h33,       32'h100,       32'h12,       32'h13,       32'h100};

      // Reset held across edges with live D inputs: state must stay cleared.
      reset = 1'b1; stallE = 1'b0; flushE = 1'b0;
      rd1D = 32'h5; rd2D = 32'h7; signimmD = 32'h0;
      rsD = 5'd3; rtD = 5'd4; rdD = 5'd1;
      regwriteD = 1'b1; memtoregD = 1'b1; memwriteD = 1'b1;
      alusrcD = 1'b0; regdstD = 1'b0; alucontrolD = 3'b010;
      clear_mw();
      step();
      step();
      chk_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         rsD = vec[i].rs; rtD = vec[i].rt; rdD = vec[i].rd;
         rd1D = vec[i].rd1; rd2D = vec[i].rd2; signimmD = vec[i].imm;
         alusrcD = vec[i].alusrc; regdstD = vec[i].regdst; alucontrolD = vec[i].alu;
         regwriteD = i[0]; memwriteD = i[1]; memtoregD = i[2];
         regwriteM = vec[i].rw_m; writeregM = vec[i].wr_m; aluoutM = vec[i].aluout_m;
         regwriteW = vec[i].rw_w; writeregW = vec[i].wr_w; resultW = vec[i].res_w;
         step();
         chk($sformatf("v%0d.validE", i),      {31'd0, validE},      32'd1);
         chk($sformatf("v%0d.rsE", i),         {27'd0, rsE},         {27'd0, vec[i].rs});
         chk($sformatf("v%0d.rtE", i),         {27'd0, rtE},         {27'd0, vec[i].rt});
         chk($sformatf("v%0d.alucontrolE", i), {29'd0, alucontrolE}, {29'd0, vec[i].alu});
         chk($sformatf("v%0d.writeregE", i),   {27'd0, writeregE},   {27'd0, vec[i].e_wreg});
         chk($sformatf("v%0d.regwriteE", i),   {31'd0, regwriteE},   {31'd0, i[0]});
         chk($sformatf("v%0d.memwriteE", i),   {31'd0, memwriteE},   {31'd0, i[1]});
         chk($sformatf("v%0d.memtoregE", i),   {31'd0, memtoregE},   {31'd0, i[2]});
         chk($sformatf("v%0d.forwardaE", i),   {30'd0, forwardaE},   c_fwd ? {30'd0, vec[i].e_fa} : 32'd0);
         chk($sformatf("v%0d.forwardbE", i),   {30'd0, forwardbE},   c_fwd ? {30'd0, vec[i].e_fb} : 32'd0);
         chk($sformatf("v%0d.srcaE", i),       srcaE,      c_fwd ? vec[i].e_srca : vec[i].n_srca);
         chk($sformatf("v%0d.writedataE", i),  writedataE, c_fwd ? vec[i].e_wd   : vec[i].n_wd);
         chk($sformatf("v%0d.srcbE", i),       srcbE,      c_fwd ? vec[i].e_srcb : vec[i].n_srcb);
      end

      // Stall: load a known instruction, then hold it against new D inputs.
      clear_mw();
      rsD = 5'd3; rtD = 5'd4; rdD = 5'd0; rd1D = 32'h5; rd2D = 32'h7; signimmD = 32'h0;
      alusrcD = 1'b0; regdstD = 1'b0; alucontrolD = 3'b010;
      regwriteD = 1'b1; memwriteD = 1'b1; memtoregD = 1'b0;
      step();
      stallE = 1'b1;
      rsD = 5'd10; rtD = 5'd11; rdD = 5'd12; rd1D = 32'hDEAD0001; rd2D = 32'hDEAD0002;
      signimmD = 32'hDEAD0003; alusrcD = 1'b1; regdstD = 1'b1; alucontrolD = 3'b101;
      regwriteD = 1'b0; memwriteD = 1'b0; memtoregD = 1'b1;
      for (int c = 0; c < 2; c++) begin
         step();
         chk($sformatf("stall%0d.rsE", c),         {27'd0, rsE},         32'd3);
         chk($sformatf("stall%0d.rtE", c),         {27'd0, rtE},         32'd4);
         chk($sformatf("stall%0d.writeregE", c),   {27'd0, writeregE},   32'd4);
         chk($sformatf("stall%0d.alucontrolE", c), {29'd0, alucontrolE}, 32'b010);
         chk($sformatf("stall%0d.srcaE", c),       srcaE,                32'h5);
         chk($sformatf("stall%0d.srcbE", c),       srcbE,                32'h7);
         chk($sformatf("stall%0d.regwriteE", c),   {31'd0, regwriteE},   32'd1);
         chk($sformatf("stall%0d.memwriteE", c),   {31'd0, memwriteE},   32'd1);
         chk($sformatf("stall%0d.memtoregE", c),   {31'd0, memtoregE},   32'd0);
         chk($sformatf("stall%0d.validE", c),      {31'd0, validE},      32'd1);
      end

      // While stalled, forwarding follows the live M input with no clock edge.
      regwriteM = 1'b1; writeregM = 5'd3; aluoutM = 32'h44;
      #1;
      chk("stallfwd.forwardaE", {30'd0, forwardaE}, c_fwd ? 32'b10 : 32'd0);
      chk("stallfwd.srcaE",     srcaE,              c_fwd ? 32'h44 : 32'h5);
      aluoutM = 32'h45;
      #1;
      chk("stallfwd2.srcaE",    srcaE,              c_fwd ? 32'h45 : 32'h5);

      // Stall and flush together: flush wins and a bubble is loaded.
      flushE = 1'b1;
      step();
      chk_all_zero("flush");
      stallE = 1'b0; flushE = 1'b0;

      // Reload, then assert reset between clock edges.
      clear_mw();
      rsD = 5'd6; rtD = 5'd7; rdD = 5'd8; rd1D = 32'h61; rd2D = 32'h71; signimmD = 32'h0;
      alusrcD = 1'b0; regdstD = 1'b1; alucontrolD = 3'b110;
      regwriteD = 1'b1; memwriteD = 1'b0; memtoregD = 1'b1;
      step();
      chk("reload.validE",    {31'd0, validE},    32'd1);
      chk("reload.writeregE", {27'd0, writeregE}, 32'd8);
      chk("reload.srcaE",     srcaE,              32'h61);
      #2;
      reset = 1'b1;
      #1;
      chk_all_zero("asyncreset");
      #1;
      reset = 1'b0;
      step();
      chk("postreset.validE", {31'd0, validE}, 32'd1);
      chk("postreset.srcbE",  srcbE,           32'h71);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
